// File: rtl/chunk_serializer.sv
// Word-to-slice serializer: accepts one WIDTH-bit operand per handshake and emits it
// as CHUNK-bit slices, least-significant first, with first/last/index markers.
module chunk_serializer #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 3,
    localparam int NCHUNKS = (WIDTH + CHUNK - 1) / CHUNK,
    localparam int IDXW = (NCHUNKS > 1) ? $clog2(NCHUNKS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [CHUNK-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_first,
    output logic             out_last,
    output logic [IDXW-1:0]  out_idx
);
    localparam int PADW = NCHUNKS * CHUNK;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNKS - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    state_t           r_state;
    logic [PADW-1:0]  r_word;
    logic [IDXW-1:0]  r_idx;
    logic [CHUNK-1:0] r_out;
    logic             r_first;
    logic             r_last;

    logic [PADW-1:0]  w_in_pad;
    logic [IDXW-1:0]  w_idx_inc;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [CHUNK-1:0] w_slices [NCHUNKS];

    // Zero-extension of the operand supplies the padding bits of the top slice.
    assign w_in_pad  = PADW'(in);
    assign w_idx_inc = r_idx + IDXW'(1);

    for (genvar gi = 0; gi < NCHUNKS; gi++) begin : g_slice
        assign w_slices[gi] = r_word[gi*CHUNK +: CHUNK];
    end

    assign out_valid  = en && (r_state == ST_SEND);
    // r_last is only meaningful in SEND; the IDLE term covers every other case.
    assign in_ready   = en && ((r_state == ST_IDLE) || (r_last && out_ready));
    assign w_in_xfer  = en && in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    assign out       = r_out;
    assign out_first = r_first;
    assign out_last  = r_last;
    assign out_idx   = r_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_idx   <= '0;
            r_out   <= '0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_in_xfer) begin
                r_state <= ST_SEND;
                r_word  <= w_in_pad;
                r_idx   <= '0;
                r_out   <= w_in_pad[CHUNK-1:0];
                r_first <= 1'b1;
                r_last  <= (NCHUNKS == 1);
            end
        end else if (w_out_xfer) begin
            if (!r_last) begin
                r_idx   <= w_idx_inc;
                r_out   <= w_slices[w_idx_inc];
                r_first <= 1'b0;
                r_last  <= (w_idx_inc == LAST_IDX);
            end else if (w_in_xfer) begin
                // Back-to-back word: the last slice leaves as the next word enters.
                r_word  <= w_in_pad;
                r_idx   <= '0;
                r_out   <= w_in_pad[CHUNK-1:0];
                r_first <= 1'b1;
                r_last  <= (NCHUNKS == 1);
            end else begin
                r_state <= ST_IDLE;
                r_idx   <= '0;
                r_out   <= '0;
                r_first <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end
endmodule

// File: doc/chunk_serializer.md
# chunk_serializer

Transmit-side companion to the pipelined-math skew datapath. Accepts one full `WIDTH`-bit operand per handshake and emits it as a sequence of `CHUNK`-bit slices, least-significant chunk first, one slice per accepted output cycle. Slices carry first/last/index markers so a chunk-serial consumer, e.g. a pipelined carry chain, can reassemble or process them. It sits between a word-parallel producer and any chunk-at-a-time datapath stage, and supports full backpressure and the global `en` stall.

## Interface
- `WIDTH`, 8: operand width in bits, ≥1.
- `CHUNK`, 3: slice width in bits, ≥1.
- `NCHUNKS` (localparam) = `ceil_division(WIDTH, CHUNK)`.
- `IDXW` (localparam) = max(1, $clog2(`NCHUNKS`)).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: global enable; 0 = stall (no state change, no handshakes).
- `in` in `WIDTH`: operand word.
- `in_valid` in 1: producer offers `in`.
- `in_ready` out 1: block can accept `in` this cycle.
- `out` out `CHUNK`: current slice.
- `out_valid` out 1: `out` and markers are valid.
- `out_ready` in 1: consumer takes the slice this cycle.
- `out_first` out 1: slice index == 0.
- `out_last` out 1: slice index == `NCHUNKS`-1.
- `out_idx` out `IDXW`: index of current slice.

## Operation
- The state machine has two states:
  - IDLE: no word held.
  - SEND: holding register `word` and counter `idx` are active.
- Input transfer is `en && in_valid && in_ready`. Output transfer is `en && out_valid && out_ready`.
- `in_ready` = `en && (state==IDLE || (out_last && out_ready))`. This is combinational and allows back-to-back words.
- `out_valid` = `en && state==SEND`. While `en`=0, `out_valid`=0 and `in_ready`=0.
- Slice content: `out` = `word_padded[idx*CHUNK +: CHUNK]`.
  - `word_padded` is `word` zero-extended to `NCHUNKS*CHUNK` bits.
  - The top slice therefore has zeros in its bits ≥ `WIDTH - (NCHUNKS-1)*CHUNK`.
- Transitions:
  - IDLE + input transfer: load `word` ← `in`, `idx` ← 0, go to SEND.
  - SEND + output transfer with idx < `NCHUNKS`-1: `idx` ← `idx`+1.
  - SEND + output transfer with idx == `NCHUNKS`-1 and input transfer in the same cycle: load new word, `idx` ← 0, stay in SEND.
  - SEND + output transfer with idx == `NCHUNKS`-1 and no input transfer: go to IDLE, `idx` ← 0.
  - SEND + no output transfer: hold everything. Data and markers stay stable while `out_valid` && !`out_ready`.
- `NCHUNKS`==1 (`CHUNK`≥`WIDTH`): every slice has `out_first`=`out_last`=1, and `out` is `in` zero-extended.
- Outputs while not in SEND:
  - `out`, `out_first`, `out_last`, `out_idx` are driven from registers and not checked by the consumer.
  - They are required to be 0 after reset.
- `en` falling mid-word: `idx` and `word` are frozen. Emission resumes at the same index when `en` returns.
- `rst` mid-word: the partially sent word is discarded with no further slices.

## Timing
- Reset values (cycle after `rst` high):
  - state IDLE, `idx`=0, `word`=0.
  - `out`=0, `out_valid`=0, `out_first`=0, `out_last`=0, `out_idx`=0.
  - `in_ready`=`en`.
- Latency: a word accepted at edge k presents slice 0 in the cycle after edge k. With `out_ready` held high, slice i is presented in cycle k+1+i.
- Throughput: one word per `NCHUNKS` cycles with no idle cycle between words when `in_valid` is held high.
- `in_ready` and `out_valid` depend combinationally on `en` and `out_ready`, with no path from `in_valid` to `out_valid`. `out` is register-driven.
- `rst` has priority over `en` and over every handshake.

## Test plan
- `WIDTH`=8, `CHUNK`=3, `in`=0xB5 accepted once, `out_ready`=1: slices 5, 6, 2 on three consecutive cycles.
  - idx 0, 1, 2; `out_first` on slice 0 only, `out_last` on slice 2 only.
  - IDLE afterwards with `in_ready`=1.
- Back-to-back: 0xB5 then 0xFF with `in_valid` held high: six consecutive valid slices 5, 6, 2, 7, 7, 3 with no gap.
  - `in_ready` is high exactly during the last-slice cycles.
- Backpressure: `out_ready`=0 for 4 cycles during slice 1 of 0xB5: `out`=6 and `out_idx`=1 are held stable, `in_ready`=0.
  - After release, slices 6 then 2.
- Stall: `en`=0 for 3 cycles at slice 1: `out_valid`=0 and `in_ready`=0.
  - On resume, slices 6 then 2; no slice is lost or duplicated.
- Reset mid-word: `rst` during slice 1 of 0xB5: the next cycle has `out_valid`=0 and `out`=0. The next accepted word 0x01 yields slices 1, 0, 0.
- Random: 1000 words with random `in_valid`, `out_ready` and `en`; a scoreboard reassembles the slices and compares them to the accepted words in order.
  - Also run with `WIDTH`=8, `CHUNK`=8: one slice per word, `out_first`=`out_last`=1.
